dma_priority_arbiter: RTL and testbench

//  Channel arbiter and hold-request sequencer for the 8237A-style DMA controller.
//  - Combines hardware DREQs and software request bits, applies mask and command

---
 rtl/dma_priority_arbiter_pkg.sv | 11 +
 rtl/dma_priority_arbiter_if.sv | 36 +++
 rtl/dma_priority_arbiter_prio_encoder.sv | 31 +++
 rtl/dma_priority_arbiter.sv | 122 ++++++++++++
 tb/tb_dma_priority_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_priority_arbiter_pkg.sv
// Shared types and command-register bit positions for the DMA channel arbiter.
package dma_pkg;

    typedef enum logic [1:0] {IDLE, HREQ, GRANT, RELEASE} arb_state_t;

    localparam int CMD_DISABLE = 2;
    localparam int CMD_ROTATE  = 4;
    localparam int CMD_DREQ_LO = 6;
    localparam int CMD_DACK_HI = 7;

endpackage

// File: rtl/dma_priority_arbiter_if.sv
// Bus between register file / timing FSM / CPU hold logic and the channel arbiter.
// arbState is the arbiter FSM state brought out for observation.
interface dma_arb_if import dma_pkg::*; #(
    parameter int NCH = 4
);
    localparam int CHW = $clog2(NCH);

    logic           masterClear;
    logic [7:0]     commandReg;
    logic [7:0]     maskReg;
    logic [7:0]     requestReg;
    logic [NCH-1:0] dreq;
    logic           hlda;
    logic           svcDone;

    logic           hrq;
    logic [NCH-1:0] dack;
    logic           grantValid;
    logic [CHW-1:0] grantCh;
    logic [CHW-1:0] prioPtr;
    arb_state_t     arbState;

    // Handshakes: hrq is held until hlda is seen; a grant lives from the cycle
    // after hlda until the cycle after svcDone (or hlda falling), with no
    // acknowledgement of svcDone beyond the grant dropping.
    modport master (
        output masterClear, commandReg, maskReg, requestReg, dreq, hlda, svcDone,
        input  hrq, dack, grantValid, grantCh, prioPtr, arbState
    );

    modport slave (
        input  masterClear, commandReg, maskReg, requestReg, dreq, hlda, svcDone,
        output hrq, dack, grantValid, grantCh, prioPtr, arbState
    );

endinterface

// File: rtl/dma_priority_arbiter_prio_encoder.sv
// Circular first-one finder: searches req upward from start, wrapping mod NCH.
module dma_prio_encoder #(
    parameter int  NCH = 4,
    localparam int CHW = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [CHW-1:0] start,
    output logic           found,
    output logic [CHW-1:0] idx
);

    int             pos;
    logic [CHW-1:0] posIdx;

    // Walk from the lowest priority back to start so the last hit is the winner.
    always_comb begin
        found  = 1'b0;
        idx    = '0;
        pos    = 0;
        posIdx = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            pos    = (int'(start) + i) % NCH;
            posIdx = CHW'(pos);
            if (req[posIdx]) begin
                found = 1'b1;
                idx   = posIdx;
            end
        end
    end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DMA channel arbiter and HRQ/HLDA sequencer. Define DMA_DREQ_SYNC_EN to pass
// dreq through a 2-flop synchronizer before polarity and mask are applied.
module dma_priority_arbiter import dma_pkg::*; #(
    parameter int NCH = 4
) (
    input logic      CLK,
    input logic      RESET,
    dma_arb_if.slave bus
);

    localparam int CHW = $clog2(NCH);

    logic [NCH-1:0] dreqS;
    logic [NCH-1:0] req;
    logic           anyReq;
    logic           rotate;
    logic           ctrlOff;
    logic           found;
    logic [CHW-1:0] winIdx;
    logic [CHW-1:0] searchStart;

    arb_state_t     state, stateNext;
    logic [CHW-1:0] grantQ, grantNext;
    logic [CHW-1:0] ptrQ, ptrNext;
    logic [NCH-1:0] grantVec;
    logic           unusedCfg;

`ifdef DMA_DREQ_SYNC_EN
    logic [NCH-1:0] sync1, sync2;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else if (bus.masterClear) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= bus.dreq;
            sync2 <= sync1;
        end
    end

    assign dreqS = sync2 ^ {NCH{bus.commandReg[CMD_DREQ_LO]}};
`else
    assign dreqS = bus.dreq ^ {NCH{bus.commandReg[CMD_DREQ_LO]}};
`endif

    // Software requests bypass the mask.
    assign req         = (dreqS & ~bus.maskReg[NCH-1:0]) | bus.requestReg[NCH-1:0];
    assign anyReq      = |req;
    assign rotate      = bus.commandReg[CMD_ROTATE];
    assign ctrlOff     = bus.commandReg[CMD_DISABLE];
    assign searchStart = rotate ? ptrQ : '0;

    dma_prio_encoder #(.NCH(NCH)) u_enc (
        .req   (req),
        .start (searchStart),
        .found (found),
        .idx   (winIdx)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state  <= IDLE;
            grantQ <= '0;
            ptrQ   <= '0;
        end else if (bus.masterClear) begin
            state  <= IDLE;
            grantQ <= '0;
            ptrQ   <= '0;
        end else begin
            state  <= stateNext;
            grantQ <= grantNext;
            ptrQ   <= ptrNext;
        end
    end

    always_comb begin
        stateNext = state;
        grantNext = grantQ;
        ptrNext   = rotate ? ptrQ : '0;
        case (state)
            IDLE: begin
                if (anyReq && !ctrlOff) stateNext = HREQ;
            end
            HREQ: begin
                if (bus.hlda && found) begin
                    stateNext = GRANT;
                    grantNext = winIdx;
                end else if (!anyReq) begin
                    stateNext = IDLE;
                end
            end
            GRANT: begin
                // svcDone wins over a simultaneous hlda drop so the pointer still advances.
                if (bus.svcDone) begin
                    stateNext = RELEASE;
                    if (rotate) ptrNext = (grantQ == CHW'(NCH - 1)) ? '0 : grantQ + 1'b1;
                end else if (!bus.hlda) begin
                    stateNext = IDLE;
                    grantNext = '0;
                end
            end
            RELEASE: begin
                if (!bus.hlda) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign grantVec       = (state == GRANT) ? ({{(NCH-1){1'b0}}, 1'b1} << grantQ) : '0;
    assign bus.dack       = bus.commandReg[CMD_DACK_HI] ? grantVec : ~grantVec;
    assign bus.hrq        = (state == HREQ) || (state == GRANT);
    assign bus.grantValid = (state == GRANT);
    assign bus.grantCh    = grantQ;
    assign bus.prioPtr    = ptrQ;
    assign bus.arbState   = state;

    assign unusedCfg = ^{bus.commandReg, bus.maskReg, bus.requestReg};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed and randomized checks of dma_priority_arbiter against a transaction-level model.
module tb_dma_priority_arbiter;
    import dma_pkg::*;

`ifdef DMA_DREQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic CLK;
    logic RESET;
    int   checks;
    int   failures;
    int   mptr;

    dma_arb_if #(.NCH(4)) bus ();

    dma_priority_arbiter #(.NCH(4)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitHrq(input string tag);
        int n;
        n = 0;
        while (bus.hrq !== 1'b1 && n < 8) begin
            step(1);
            n++;
        end
        check(tag, 32'(bus.hrq), 32'd1);
    endtask

    // Highest-priority requester scanning upward from start, wrapping over 4 channels.
    function automatic int pick(input logic [3:0] r, input int start);
        int p;
        for (int i = 0; i < 4; i++) begin
            p = (start + i) % 4;
            if (((r >> p) & 4'd1) != 4'd0) return p;
        end
        return 0;
    endfunction

    initial begin
        bit          rot, pol, dhi;
        logic [3:0]  rd, rm, rrr, reqv, polMask, vec, expD;
        int          expCh;

        checks = 0;
        failures = 0;
        mptr = 0;
        RESET = 1'b0;
        bus.masterClear = 1'b0;
        bus.commandReg  = 8'h00;
        bus.maskReg     = 8'h00;
        bus.requestReg  = 8'h00;
        bus.dreq        = 4'h0;
        bus.hlda        = 1'b0;
        bus.svcDone     = 1'b0;
        #2;
        check("rst_hrq",   32'(bus.hrq), 32'd0);
        check("rst_gv",    32'(bus.grantValid), 32'd0);
        check("rst_gch",   32'(bus.grantCh), 32'd0);
        check("rst_ptr",   32'(bus.prioPtr), 32'd0);
        check("rst_dack",  32'(bus.dack), 32'hF);
        check("rst_state", 32'(bus.arbState), 32'(IDLE));
        step(2);
        RESET = 1'b1;
        step(1);

        // Fixed priority, exact request latency, grant and release.
        bus.dreq = 4'b0110;
        check("t1_hrq_now", 32'(bus.hrq), 32'd0);
        step(LAT - 1);
        check("t1_hrq_early", 32'(bus.hrq), 32'd0);
        step(1);
        check("t1_hrq", 32'(bus.hrq), 32'd1);
        bus.hlda = 1'b1;
        step(1);
        check("t1_gv", 32'(bus.grantValid), 32'd1);
        check("t1_gch", 32'(bus.grantCh), 32'd1);
        check("t1_dack", 32'(bus.dack), 32'hD);
        bus.dreq = 4'b0000;
        step(3);
        check("t1_hold", 32'(bus.grantCh), 32'd1);
        check("t1_hold_gv", 32'(bus.grantValid), 32'd1);
        bus.svcDone = 1'b1;
        step(1);
        bus.svcDone = 1'b0;
        check("t1_rel_gv", 32'(bus.grantValid), 32'd0);
        check("t1_rel_hrq", 32'(bus.hrq), 32'd0);
        check("t1_rel_dack", 32'(bus.dack), 32'hF);
        check("t1_rel_ptr", 32'(bus.prioPtr), 32'd0);
        bus.hlda = 1'b0;
        step(1);
        check("t1_idle", 32'(bus.arbState), 32'(IDLE));

        // Rotating priority, all channels requesting.
        bus.commandReg = 8'h10;
        bus.dreq = 4'hF;
        for (int k = 0; k < 4; k++) begin
            waitHrq("t2_hrq");
            bus.hlda = 1'b1;
            step(1);
            check("t2_gch", 32'(bus.grantCh), 32'(k));
            bus.svcDone = 1'b1;
            step(1);
            bus.svcDone = 1'b0;
            check("t2_ptr", 32'(bus.prioPtr), 32'((k + 1) % 4));
            bus.hlda = 1'b0;
            step(1);
        end
        bus.dreq = 4'h0;
        step(4);
        check("t2_quiet", 32'(bus.hrq), 32'd0);

        // Masked hardware request vs. software request.
        bus.commandReg = 8'h00;
        bus.maskReg = 8'h01;
        bus.dreq = 4'b0001;
        step(4);
        check("t3_masked", 32'(bus.hrq), 32'd0);
        bus.requestReg = 8'h01;
        step(1);
        check("t3_swreq_hrq", 32'(bus.hrq), 32'd1);
        bus.hlda = 1'b1;
        step(1);
        check("t3_gch", 32'(bus.grantCh), 32'd0);
        check("t3_gv", 32'(bus.grantValid), 32'd1);
        bus.requestReg = 8'h00;
        bus.dreq = 4'b0000;
        bus.svcDone = 1'b1;
        step(1);
        bus.svcDone = 1'b0;
        bus.hlda = 1'b0;
        step(4);
        check("t3_quiet", 32'(bus.hrq), 32'd0);
        bus.maskReg = 8'h00;

        // Abort (hlda falls without svcDone) leaves the pointer alone.
        bus.commandReg = 8'h10;
        bus.dreq = 4'b0100;
        waitHrq("t4_hrq");
        bus.hlda = 1'b1;
        step(1);
        check("t4_gch", 32'(bus.grantCh), 32'd2);
        bus.dreq = 4'b0000;
        step(3);
        bus.hlda = 1'b0;
        step(1);
        check("t4_abort_gv", 32'(bus.grantValid), 32'd0);
        check("t4_abort_dack", 32'(bus.dack), 32'hF);
        check("t4_abort_ptr", 32'(bus.prioPtr), 32'd0);
        check("t4_abort_hrq", 32'(bus.hrq), 32'd0);

        // svcDone together with hlda falling counts as a service.
        bus.dreq = 4'b0100;
        waitHrq("t4b_hrq");
        bus.hlda = 1'b1;
        step(1);
        check("t4b_gch", 32'(bus.grantCh), 32'd2);
        bus.dreq = 4'b0000;
        step(3);
        bus.svcDone = 1'b1;
        bus.hlda = 1'b0;
        step(1);
        bus.svcDone = 1'b0;
        check("t4b_gv", 32'(bus.grantValid), 32'd0);
        check("t4b_ptr", 32'(bus.prioPtr), 32'd3);
        step(1);
        check("t4b_idle", 32'(bus.arbState), 32'(IDLE));

        // masterClear during a grant; pointer 3 makes ch1 the winner over nothing else.
        bus.dreq = 4'b0010;
        waitHrq("t4c_hrq");
        bus.hlda = 1'b1;
        step(1);
        check("t4c_gch", 32'(bus.grantCh), 32'd1);
        bus.masterClear = 1'b1;
        step(1);
        check("t4c_gv", 32'(bus.grantValid), 32'd0);
        check("t4c_dack", 32'(bus.dack), 32'hF);
        check("t4c_ptr", 32'(bus.prioPtr), 32'd0);
        check("t4c_hrq", 32'(bus.hrq), 32'd0);
        bus.dreq = 4'b0000;
        bus.masterClear = 1'b0;
        bus.hlda = 1'b0;
        step(3);

        // Request withdrawn before hlda; controller disable blocks entry.
        bus.commandReg = 8'h00;
        bus.dreq = 4'b0001;
        waitHrq("t5_hrq");
        bus.dreq = 4'b0000;
        step(LAT);
        check("t5_withdrawn", 32'(bus.hrq), 32'd0);
        bus.commandReg = 8'h04;
        bus.dreq = 4'b1000;
        step(4);
        check("t5_disabled", 32'(bus.hrq), 32'd0);
        bus.dreq = 4'b0000;
        bus.commandReg = 8'h00;
        step(3);

        // Active-low DREQ, active-high DACK.
        bus.maskReg = 8'h0F;
        bus.commandReg = 8'hC0;
        bus.dreq = 4'b1110;
        step(3);
        check("t6_idle_hrq", 32'(bus.hrq), 32'd0);
        check("t6_idle_dack", 32'(bus.dack), 32'h0);
        bus.maskReg = 8'h00;
        waitHrq("t6_hrq");
        bus.hlda = 1'b1;
        step(1);
        check("t6_gch", 32'(bus.grantCh), 32'd0);
        check("t6_dack", 32'(bus.dack), 32'h1);
        bus.maskReg = 8'h0F;
        bus.svcDone = 1'b1;
        step(1);
        bus.svcDone = 1'b0;
        check("t6_rel_dack", 32'(bus.dack), 32'h0);
        bus.hlda = 1'b0;
        step(1);
        bus.commandReg = 8'h00;
        bus.dreq = 4'b0000;
        step(3);
        bus.maskReg = 8'h00;
        step(1);
        mptr = 0;

        // Randomized transactions against the priority model.
        for (int t = 0; t < 40; t++) begin
            rot = 1'($urandom_range(0, 1));
            pol = 1'($urandom_range(0, 1));
            dhi = 1'($urandom_range(0, 1));
            polMask = pol ? 4'hF : 4'h0;
            bus.maskReg = 8'h0F;
            bus.requestReg = 8'h00;
            bus.dreq = polMask;
            bus.commandReg = {dhi, pol, 1'b0, rot, 4'b0000};
            step(3);
            if (!rot) mptr = 0;
            check("rnd_idle_hrq", 32'(bus.hrq), 32'd0);
            check("rnd_idle_ptr", 32'(bus.prioPtr), 32'(mptr));
            rd  = 4'($urandom_range(0, 15));
            rm  = 4'($urandom_range(0, 15));
            rrr = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            bus.dreq = rd;
            bus.maskReg = {4'h0, rm};
            bus.requestReg = {4'h0, rrr};
            reqv = ((rd ^ polMask) & ~rm) | rrr;
            step(3);
            if (reqv == 4'h0) begin
                check("rnd_noreq_hrq", 32'(bus.hrq), 32'd0);
            end else begin
                check("rnd_hrq", 32'(bus.hrq), 32'd1);
                bus.hlda = 1'b1;
                step(1);
                expCh = pick(reqv, rot ? mptr : 0);
                vec = 4'b0001 << expCh;
                expD = dhi ? vec : ~vec;
                check("rnd_gch", 32'(bus.grantCh), 32'(expCh));
                check("rnd_dack", 32'(bus.dack), 32'(expD));
                bus.dreq = 4'($urandom_range(0, 15));
                bus.maskReg = 8'($urandom_range(0, 15));
                bus.requestReg = 8'($urandom_range(0, 15));
                step(2);
                check("rnd_gch_held", 32'(bus.grantCh), 32'(expCh));
                bus.dreq = polMask;
                bus.requestReg = 8'h00;
                bus.maskReg = 8'h0F;
                step(3);
                if ($urandom_range(0, 3) != 0) begin
                    bus.svcDone = 1'b1;
                    step(1);
                    bus.svcDone = 1'b0;
                    if (rot) mptr = (expCh + 1) % 4;
                    check("rnd_svc_gv", 32'(bus.grantValid), 32'd0);
                    check("rnd_svc_ptr", 32'(bus.prioPtr), 32'(mptr));
                    bus.hlda = 1'b0;
                    step(1);
                end else begin
                    bus.hlda = 1'b0;
                    step(1);
                    check("rnd_abort_gv", 32'(bus.grantValid), 32'd0);
                    check("rnd_abort_ptr", 32'(bus.prioPtr), 32'(mptr));
                end
                check("rnd_end_dack", 32'(bus.dack), 32'(dhi ? 4'h0 : 4'hF));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
